nor_flash_responder: RTL and testbench

- Synthesizable, cycle-based responder model of the board's parallel NOR flash (StrataFlash-style command set).
- Sits on the same CE/WE/OE/ADDR/DATA bus that the flash command sequencers drive, in place of the physical device.
- Decodes the unlock/lock, read-ID, block-erase, program-word, read-status and clear-status sequences, with a status register, per-block lock bits and busy timers.
- Its purpose is closed-loop on-board and simulation checking of the sequencers.

---
 rtl/nor_flash_pkg.sv | 38 +++
 rtl/nor_flash_array.sv | 28 ++
 rtl/nor_flash_responder.sv | 275 +++++++++++++++++++++++++++
 tb/tb_nor_flash_responder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nor_flash_pkg.sv
// Shared definitions for the NOR flash responder and the command sequencers
// that drive it: command codes, status-register bit positions and state enums.
package nor_flash_pkg;

  // Command codes (low byte of the data bus; the high byte is ignored)
  localparam logic [7:0] CMD_LOCK_SETUP   = 8'h60;
  localparam logic [7:0] CMD_CONFIRM      = 8'hD0;
  localparam logic [7:0] CMD_LOCK_SET     = 8'h01;
  localparam logic [7:0] CMD_READ_ID      = 8'h90;
  localparam logic [7:0] CMD_ERASE_SETUP  = 8'h20;
  localparam logic [7:0] CMD_CLEAR_STATUS = 8'h50;
  localparam logic [7:0] CMD_READ_STATUS  = 8'h70;
  localparam logic [7:0] CMD_PROGRAM      = 8'h40;
  localparam logic [7:0] CMD_READ_ARRAY   = 8'hFF;

  // Status register bit positions
  localparam int SR_READY     = 7;
  localparam int SR_ERASE_ERR = 5;
  localparam int SR_PROG_ERR  = 4;
  localparam int SR_VPP_ERR   = 3;
  localparam int SR_LOCK_ERR  = 1;

  typedef enum logic [1:0] {
    MODE_ARRAY,
    MODE_STATUS,
    MODE_ID
  } read_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_LOCK2,
    ST_W_ERASE2,
    ST_W_PDATA,
    ST_ERASING,
    ST_PROGRAMMING
  } flash_state_e;

endpackage

// File: rtl/nor_flash_array.sv
// Flash word storage: one write port, one registered read port.
// Words are stored inverted so a RAM that powers up all-zero reads back as
// erased (16'hFFFF) without needing an initialisation image.
module nor_flash_array #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [15:0]   wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [15:0]   rd_data_o
);

  logic [15:0] mem_q [2**AW];
  logic [15:0] rd_q;

  // Single write port plus registered read (maps onto block RAM)
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= ~wr_data_i;
    end
    rd_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = ~rd_q;

endmodule

// File: rtl/nor_flash_responder.sv
// Cycle-based stand-in for the board's StrataFlash-style parallel NOR flash.
// Registers the bus, detects write commits on the WE rising edge, runs the
// command FSM with status register, per-block lock bits and busy timers.
module nor_flash_responder
  import nor_flash_pkg::*;
#(
  parameter int          NUM_BLK   = 4,
  parameter int          WORD_AW   = 6,
  parameter int          ERASE_CYC = 1000,
  parameter int          PROG_CYC  = 50,
  parameter logic [15:0] MFR_ID    = 16'h0089,
  parameter logic [15:0] DEV_ID    = 16'h8817
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        CE,
  input  logic        WE,
  input  logic        OE,
  input  logic [23:0] ADDR,
  inout  wire  [15:0] DATA,
  output logic        BUSY
);

  // NUM_BLK must be a power of two >= 2; ERASE_CYC must be >= 2**WORD_AW
  // because the block fill runs in the final 2**WORD_AW erase cycles.
  localparam int BLK_W   = $clog2(NUM_BLK);
  localparam int AW      = BLK_W + WORD_AW;
  localparam int WORDS   = 2 ** WORD_AW;
  localparam int TMR_MAX = (ERASE_CYC > PROG_CYC) ? ERASE_CYC : PROG_CYC;
  localparam int TW      = $clog2(TMR_MAX + 1);

  // Registered bus
  logic        ce_q, we_q, oe_q;
  logic [23:0] addr_q;
  logic [15:0] data_q;

  // Command state
  flash_state_e        state_q, state_d;
  read_mode_e          mode_q, mode_d;
  logic [7:0]          sr_q, sr_d;
  logic [NUM_BLK-1:0]  lock_q, lock_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [WORD_AW-1:0]  erase_cnt_q, erase_cnt_d;
  logic [AW-1:0]       op_addr_q, op_addr_d;
  logic [15:0]         prog_data_q, prog_data_d;

  // Read-out path
  logic [15:0] dout_q;
  logic        arr_sel_q;

  // Array ports
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data;

  logic             commit;
  logic [7:0]       cmd;
  logic [BLK_W-1:0] cmd_blk;
  logic [AW-1:0]    cmd_word;
  logic             drive;

  // Aliased address bits are deliberately ignored
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_q[23:16+BLK_W], addr_q[15:WORD_AW]};

  // A commit is the WE rise after a cycle with CE and WE both low
  assign commit   = ~ce_q & ~we_q & WE;
  assign cmd      = data_q[7:0];
  assign cmd_blk  = addr_q[16 +: BLK_W];
  assign cmd_word = {cmd_blk, addr_q[WORD_AW-1:0]};

  assign BUSY = (state_q == ST_ERASING) || (state_q == ST_PROGRAMMING);

  // While programming, the read port fetches the old word for the AND-merge
  assign rd_addr = (state_q == ST_PROGRAMMING) ? op_addr_q : cmd_word;

  nor_flash_array #(
    .AW (AW)
  ) u_array (
    .clk       (CLK),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Sample the bus every cycle
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ce_q   <= 1'b1;
      we_q   <= 1'b1;
      oe_q   <= 1'b1;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      ce_q   <= CE;
      we_q   <= WE;
      oe_q   <= OE;
      addr_q <= ADDR;
      data_q <= DATA;
    end
  end

  // Command FSM and operation state registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_ARRAY;
      sr_q        <= 8'h80;
      lock_q      <= '1;
      timer_q     <= '0;
      erase_cnt_q <= '0;
      op_addr_q   <= '0;
      prog_data_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      sr_q        <= sr_d;
      lock_q      <= lock_d;
      timer_q     <= timer_d;
      erase_cnt_q <= erase_cnt_d;
      op_addr_q   <= op_addr_d;
      prog_data_q <= prog_data_d;
    end
  end

  // Command decode, busy countdown and array write generation
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    sr_d        = sr_q;
    lock_d      = lock_q;
    timer_d     = timer_q;
    erase_cnt_d = erase_cnt_q;
    op_addr_d   = op_addr_q;
    prog_data_d = prog_data_q;
    wr_en       = 1'b0;
    wr_addr     = op_addr_q;
    wr_data     = 16'hFFFF;

    case (state_q)
      ST_IDLE: begin
        if (commit) begin
          case (cmd)
            CMD_LOCK_SETUP:   state_d = ST_W_LOCK2;
            CMD_ERASE_SETUP:  state_d = ST_W_ERASE2;
            CMD_PROGRAM:      state_d = ST_W_PDATA;
            CMD_READ_ID:      mode_d  = MODE_ID;
            CMD_READ_STATUS:  mode_d  = MODE_STATUS;
            CMD_READ_ARRAY:   mode_d  = MODE_ARRAY;
            CMD_CLEAR_STATUS: begin
              sr_d[SR_ERASE_ERR] = 1'b0;
              sr_d[SR_PROG_ERR]  = 1'b0;
              sr_d[SR_VPP_ERR]   = 1'b0;
              sr_d[SR_LOCK_ERR]  = 1'b0;
            end
            default: ;
          endcase
        end
      end

      ST_W_LOCK2: begin
        if (commit) begin
          state_d = ST_IDLE;
          if (cmd == CMD_CONFIRM) begin
            lock_d[cmd_blk] = 1'b0;
          end else if (cmd == CMD_LOCK_SET) begin
            lock_d[cmd_blk] = 1'b1;
          end else begin
            sr_d[SR_ERASE_ERR] = 1'b1;
            sr_d[SR_PROG_ERR]  = 1'b1;
          end
        end
      end

      ST_W_ERASE2: begin
        if (commit) begin
          state_d = ST_IDLE;
          if (cmd != CMD_CONFIRM) begin
            sr_d[SR_ERASE_ERR] = 1'b1;
            sr_d[SR_PROG_ERR]  = 1'b1;
          end else if (lock_q[cmd_blk]) begin
            sr_d[SR_ERASE_ERR] = 1'b1;
            sr_d[SR_LOCK_ERR]  = 1'b1;
          end else begin
            state_d          = ST_ERASING;
            mode_d           = MODE_STATUS;
            sr_d[SR_READY]   = 1'b0;
            timer_d          = TW'(ERASE_CYC);
            erase_cnt_d      = '0;
            op_addr_d        = {cmd_blk, {WORD_AW{1'b0}}};
          end
        end
      end

      ST_W_PDATA: begin
        if (commit) begin
          if (lock_q[cmd_blk]) begin
            state_d           = ST_IDLE;
            sr_d[SR_PROG_ERR] = 1'b1;
            sr_d[SR_LOCK_ERR] = 1'b1;
          end else begin
            state_d        = ST_PROGRAMMING;
            mode_d         = MODE_STATUS;
            sr_d[SR_READY] = 1'b0;
            timer_d        = TW'(PROG_CYC);
            op_addr_d      = cmd_word;
            prog_data_d    = data_q;
          end
        end
      end

      ST_ERASING: begin
        mode_d  = MODE_STATUS;
        timer_d = timer_q - TW'(1);
        // Fill the block in the last WORDS cycles so a reset earlier in the
        // erase leaves the array untouched.
        if (timer_q <= TW'(WORDS)) begin
          wr_en       = 1'b1;
          wr_addr     = {op_addr_q[AW-1:WORD_AW], erase_cnt_q};
          wr_data     = 16'hFFFF;
          erase_cnt_d = erase_cnt_q + 1'b1;
        end
        if (timer_q == TW'(1)) begin
          state_d        = ST_IDLE;
          sr_d[SR_READY] = 1'b1;
        end
      end

      ST_PROGRAMMING: begin
        mode_d  = MODE_STATUS;
        timer_d = timer_q - TW'(1);
        if (timer_q == TW'(1)) begin
          // Programming can only clear bits
          wr_en          = 1'b1;
          wr_addr        = op_addr_q;
          wr_data        = rd_data & prog_data_q;
          state_d        = ST_IDLE;
          sr_d[SR_READY] = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Output data register, refreshed every cycle from addr_q and the mode
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      dout_q    <= '0;
      arr_sel_q <= 1'b0;
    end else begin
      arr_sel_q <= (mode_q == MODE_ARRAY);
      case (mode_q)
        MODE_ID: begin
          case (addr_q[1:0])
            2'd0:    dout_q <= MFR_ID;
            2'd1:    dout_q <= DEV_ID;
            2'd2:    dout_q <= {15'b0, lock_q[cmd_blk]};
            default: dout_q <= 16'h0000;
          endcase
        end
        MODE_STATUS: dout_q <= {8'h00, sr_q};
        default:     dout_q <= 16'h0000;
      endcase
    end
  end

  assign drive = ~ce_q & ~oe_q & we_q;
  assign DATA  = drive ? (arr_sel_q ? rd_data : dout_q) : 16'hzzzz;

endmodule

// File: tb/tb_nor_flash_responder.sv
// Directed bench for nor_flash_responder: drives flash bus cycles and checks
// ID, lock, erase, program, error-status and reset-during-erase behaviour.
module tb_nor_flash_responder;

  localparam int ERASE_CYC = 1000;
  localparam int PROG_CYC  = 50;

  logic        CLK     = 1'b0;
  logic        RESET_N = 1'b0;
  logic        CE      = 1'b1;
  logic        WE      = 1'b1;
  logic        OE      = 1'b1;
  logic [23:0] ADDR    = '0;
  wire  [15:0] DATA;
  logic        BUSY;

  logic [15:0] tb_dout = '0;
  logic        tb_drv  = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  assign DATA = tb_drv ? tb_dout : 16'hzzzz;

  always #5 CLK = ~CLK;

  nor_flash_responder #(
    .NUM_BLK   (4),
    .WORD_AW   (6),
    .ERASE_CYC (ERASE_CYC),
    .PROG_CYC  (PROG_CYC),
    .MFR_ID    (16'h0089),
    .DEV_ID    (16'h8817)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .CE      (CE),
    .WE      (WE),
    .OE      (OE),
    .ADDR    (ADDR),
    .DATA    (DATA),
    .BUSY    (BUSY)
  );

  // One bus write; returns on the falling edge just after the commit edge
  task automatic bus_write(input logic [23:0] a, input logic [15:0] d, input bit ce_with_we = 1'b0);
    @(negedge CLK);
    ADDR = a; tb_dout = d; tb_drv = 1'b1; OE = 1'b1; CE = 1'b0; WE = 1'b0;
    repeat (2) @(negedge CLK);
    WE = 1'b1;
    if (ce_with_we) CE = 1'b1;
    @(negedge CLK);
    CE = 1'b1; tb_drv = 1'b0;
    $display("write %06h <= %04h", a, d);
  endtask

  // One bus read with a 3-cycle wait
  task automatic bus_read(input logic [23:0] a, output logic [15:0] d);
    @(negedge CLK);
    ADDR = a; CE = 1'b0; OE = 1'b0;
    repeat (3) @(negedge CLK);
    d = DATA;
    CE = 1'b1; OE = 1'b1;
    $display("read  %06h => %04h", a, d);
  endtask

  task automatic test_reset();
    logic [15:0] d;
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: got %b want 0", BUSY);
    end
    bus_write(24'h000000, 16'h0070);
    bus_read(24'h000000, d);
    n_cmp++;
    if (d !== 16'h0080) begin
      n_err++; $display("FAIL reset_status: got %04h want 0080", d);
    end
  endtask

  task automatic test_read_id();
    logic [15:0] d;
    bus_write(24'h3F0000, 16'h0090);
    bus_read(24'h3F0000, d);
    n_cmp++;
    if (d !== 16'h0089) begin n_err++; $display("FAIL id_mfr: got %04h want 0089", d); end
    bus_read(24'h3F0001, d);
    n_cmp++;
    if (d !== 16'h8817) begin n_err++; $display("FAIL id_dev: got %04h want 8817", d); end
    bus_read(24'h3F0002, d);
    n_cmp++;
    if (d !== 16'h0001) begin n_err++; $display("FAIL id_lock: got %04h want 0001", d); end
    bus_read(24'h3F0003, d);
    n_cmp++;
    if (d !== 16'h0000) begin n_err++; $display("FAIL id_rsvd: got %04h want 0000", d); end
    // Back to array, then re-enter ID with a junk high byte and CE rising with WE
    bus_write(24'h000000, 16'h00FF);
    bus_write(24'h3F0000, 16'hAB90, 1'b1);
    bus_read(24'h3F0001, d);
    n_cmp++;
    if (d !== 16'h8817) begin n_err++; $display("FAIL id_hibyte_ce_rise: got %04h want 8817", d); end
  endtask

  task automatic test_lock();
    logic [15:0] d;
    bus_write(24'h3F0000, 16'h0060);
    bus_write(24'h3F0000, 16'h00D0);
    bus_write(24'h3F0000, 16'h0090);
    bus_read(24'h3F0002, d);
    n_cmp++;
    if (d !== 16'h0000) begin n_err++; $display("FAIL unlock_blk3: got %04h want 0000", d); end
    bus_read(24'h000002, d);
    n_cmp++;
    if (d !== 16'h0001) begin n_err++; $display("FAIL blk0_still_locked: got %04h want 0001", d); end
    bus_write(24'h3F0000, 16'h0060);
    bus_write(24'h3F0000, 16'h0001);
    bus_write(24'h3F0000, 16'h0090);
    bus_read(24'h3F0002, d);
    n_cmp++;
    if (d !== 16'h0001) begin n_err++; $display("FAIL relock_blk3: got %04h want 0001", d); end
  endtask

  task automatic test_erase();
    logic [15:0] d;
    logic [15:0] mid;
    int cnt;
    bus_write(24'h3F0000, 16'h0060);
    bus_write(24'h3F0000, 16'h00D0);
    bus_write(24'h3F0000, 16'h0020);
    bus_write(24'h3F0000, 16'h00D0);
    // Keep a read open on the bus through the whole erase
    ADDR = 24'h3F0000; CE = 1'b0; OE = 1'b0;
    cnt = 0; mid = 16'hDEAD;
    while (BUSY === 1'b1 && cnt < 3 * ERASE_CYC) begin
      cnt++;
      if (cnt == 10) mid = DATA;
      @(negedge CLK);
    end
    $display("erase busy for %0d cycles", cnt);
    n_cmp++;
    if (cnt != ERASE_CYC) begin n_err++; $display("FAIL erase_busy_len: got %0d want %0d", cnt, ERASE_CYC); end
    n_cmp++;
    if (mid !== 16'h0000) begin n_err++; $display("FAIL erase_status_busy: got %04h want 0000", mid); end
    repeat (3) @(negedge CLK);
    d = DATA;
    CE = 1'b1; OE = 1'b1;
    n_cmp++;
    if (d !== 16'h0080) begin n_err++; $display("FAIL erase_status_done: got %04h want 0080", d); end
    bus_write(24'h3F0000, 16'h00FF);
    bus_read(24'h3F0005, d);
    n_cmp++;
    if (d !== 16'hFFFF) begin n_err++; $display("FAIL erase_word5: got %04h want FFFF", d); end
    bus_read(24'h3F003F, d);
    n_cmp++;
    if (d !== 16'hFFFF) begin n_err++; $display("FAIL erase_word63: got %04h want FFFF", d); end
  endtask

  task automatic test_program();
    logic [15:0] d;
    int cnt;
    bus_write(24'h3F0000, 16'h0040);
    bus_write(24'h3F0000, 16'h0052);
    cnt = 0;
    while (BUSY === 1'b1 && cnt < 3 * PROG_CYC) begin
      cnt++;
      @(negedge CLK);
    end
    $display("program busy for %0d cycles", cnt);
    n_cmp++;
    if (cnt != PROG_CYC) begin n_err++; $display("FAIL prog_busy_len: got %0d want %0d", cnt, PROG_CYC); end
    bus_read(24'h3F0000, d);
    n_cmp++;
    if (d !== 16'h0080) begin n_err++; $display("FAIL prog_status: got %04h want 0080", d); end
    bus_write(24'h3F0000, 16'h00FF);
    bus_read(24'h3F0000, d);
    n_cmp++;
    if (d !== 16'h0052) begin n_err++; $display("FAIL prog_word: got %04h want 0052", d); end
    bus_write(24'h3F0000, 16'h0040);
    bus_write(24'h3F0000, 16'h00F0);
    cnt = 0;
    while (BUSY === 1'b1 && cnt < 3 * PROG_CYC) begin
      cnt++;
      @(negedge CLK);
    end
    n_cmp++;
    if (cnt != PROG_CYC) begin n_err++; $display("FAIL prog2_busy_len: got %0d want %0d", cnt, PROG_CYC); end
    bus_write(24'h3F0000, 16'h00FF);
    bus_read(24'h3F0000, d);
    n_cmp++;
    if (d !== 16'h0050) begin n_err++; $display("FAIL prog_and_merge: got %04h want 0050", d); end
    bus_read(24'h3F0001, d);
    n_cmp++;
    if (d !== 16'hFFFF) begin n_err++; $display("FAIL prog_neighbour: got %04h want FFFF", d); end
  endtask

  task automatic test_locked_errors();
    logic [15:0] d;
    bus_write(24'h000000, 16'h0020);
    bus_write(24'h000000, 16'h00D0);
    n_cmp++;
    if (BUSY !== 1'b0) begin n_err++; $display("FAIL locked_erase_busy: got %b want 0", BUSY); end
    bus_write(24'h000000, 16'h0070);
    bus_read(24'h000000, d);
    n_cmp++;
    if (d !== 16'h00A2) begin n_err++; $display("FAIL locked_erase_sr: got %04h want 00A2", d); end
    bus_write(24'h000000, 16'h0050);
    bus_write(24'h000000, 16'h0070);
    bus_read(24'h000000, d);
    n_cmp++;
    if (d !== 16'h0080) begin n_err++; $display("FAIL clear_status: got %04h want 0080", d); end
    bus_write(24'h000000, 16'h0060);
    bus_write(24'h000000, 16'h0033);
    bus_write(24'h000000, 16'h0070);
    bus_read(24'h000000, d);
    n_cmp++;
    if (d !== 16'h00B0) begin n_err++; $display("FAIL bad_lock_seq: got %04h want 00B0", d); end
    bus_write(24'h000000, 16'h0050);
    bus_write(24'h000000, 16'h0040);
    bus_write(24'h000000, 16'h1234);
    bus_write(24'h000000, 16'h0070);
    bus_read(24'h000000, d);
    n_cmp++;
    if (d !== 16'h0092) begin n_err++; $display("FAIL locked_prog_sr: got %04h want 0092", d); end
    bus_write(24'h000000, 16'h0050);
  endtask

  task automatic test_reset_mid_erase();
    logic [15:0] d;
    bus_write(24'h3F0000, 16'h0060);
    bus_write(24'h3F0000, 16'h00D0);
    bus_write(24'h3F0000, 16'h0020);
    bus_write(24'h3F0000, 16'h00D0);
    repeat (ERASE_CYC / 2) @(negedge CLK);
    n_cmp++;
    if (BUSY !== 1'b1) begin n_err++; $display("FAIL mid_erase_busy: got %b want 1", BUSY); end
    RESET_N = 1'b0;
    #1;
    n_cmp++;
    if (BUSY !== 1'b0) begin n_err++; $display("FAIL async_reset_busy: got %b want 0", BUSY); end
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    bus_write(24'h000000, 16'h0070);
    bus_read(24'h000000, d);
    n_cmp++;
    if (d !== 16'h0080) begin n_err++; $display("FAIL post_reset_status: got %04h want 0080", d); end
    bus_write(24'h000000, 16'h00FF);
    bus_read(24'h3F0000, d);
    n_cmp++;
    if (d !== 16'h0050) begin n_err++; $display("FAIL post_reset_array: got %04h want 0050", d); end
    bus_write(24'h3F0000, 16'h0090);
    bus_read(24'h3F0002, d);
    n_cmp++;
    if (d !== 16'h0001) begin n_err++; $display("FAIL post_reset_lock: got %04h want 0001", d); end
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    test_reset();
    test_read_id();
    test_lock();
    test_erase();
    test_program();
    test_locked_errors();
    test_reset_mid_erase();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
